// File: rtl/load_ext_pkg.sv
// Shared types for the load extend unit: access-size and skid-buffer state encodings,
// plus the size-to-byte-count helper used by the extraction datapath.
package load_ext_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    // Unclamped field width in bytes; the caller clamps to the datapath width.
    function automatic logic [31:0] size_bytes(input size_e sz);
        case (sz)
            SZ_BYTE:  return 32'd1;
            SZ_HALF:  return 32'd2;
            SZ_WORD:  return 32'd4;
            SZ_DWORD: return 32'd8;
            default:  return 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/load_ext_core.sv
// Combinational field extraction: shift right by byte offset, then zero/sign extend.
// Optional misalignment check under LOAD_EXT_MISALIGN_EN.
module load_ext_core
    import load_ext_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
`ifdef LOAD_EXT_MISALIGN_EN
    output logic              o_misalign,
`endif
    output logic [DATA_W-1:0] o_data
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned IDX_W = $clog2(DATA_W);

    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_extended;
    logic [31:0]       w_fbytes;
    logic [31:0]       w_fbits;
    logic [IDX_W-1:0]  w_msb_idx;
    logic              w_ext;

    // Bytes shifted in from above the top of the word are zero; nothing wraps.
    assign w_shifted = i_data >> {i_offset, 3'b000};

    always_comb begin
        w_fbytes = size_bytes(size_e'(i_size));
        if (w_fbytes > BYTES) begin
            w_fbytes = BYTES;
        end
        w_fbits   = w_fbytes << 3;
        w_msb_idx = IDX_W'(w_fbits - 32'd1);
        w_ext     = i_signed & w_shifted[w_msb_idx];
        // A full-width field has no extension bits, so i_signed drops out naturally.
        for (int unsigned i = 0; i < DATA_W; i++) begin
            w_extended[i] = (i < w_fbits) ? w_shifted[i] : w_ext;
        end
    end

`ifdef LOAD_EXT_MISALIGN_EN
    logic w_misalign;

    assign w_misalign = ((32'(i_offset) & (w_fbytes - 32'd1)) != '0);
    assign o_misalign = w_misalign;
    assign o_data     = w_misalign ? '0 : w_extended;
`else
    assign o_data = w_extended;
`endif

endmodule

// File: rtl/load_extend_unit.sv
// Pipelined load aligner/extender: one result register with a 2-entry skid buffer.
// Define LOAD_EXT_MISALIGN_EN to add the out_misalign port and zero misaligned results.
module load_extend_unit
    import load_ext_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_offset,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef LOAD_EXT_MISALIGN_EN
    output logic              out_misalign,
`endif
    output logic [DATA_W-1:0] out_data
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
`ifdef LOAD_EXT_MISALIGN_EN
        logic              misalign;
`endif
    } entry_t;

    skid_state_e       r_state;
    skid_state_e       w_state_nxt;
    entry_t            r_head;
    entry_t            r_tail;
    entry_t            w_new;
    logic [DATA_W-1:0] w_core_data;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_drain;
    logic              w_head_ld;
    logic              w_head_from_tail;
    logic              w_tail_ld;

`ifdef LOAD_EXT_MISALIGN_EN
    logic w_core_misalign;
`endif

    load_ext_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .i_data     (in_data),
        .i_offset   (in_offset),
        .i_size     (in_size),
        .i_signed   (in_signed),
`ifdef LOAD_EXT_MISALIGN_EN
        .o_misalign (w_core_misalign),
`endif
        .o_data     (w_core_data)
    );

    always_comb begin
        w_new      = '0;
        w_new.data = w_core_data;
`ifdef LOAD_EXT_MISALIGN_EN
        w_new.misalign = w_core_misalign;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_head_ld        = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_ld        = 1'b0;
        // in_ready is a function of state and reset only, never of out_ready.
        w_in_ready       = !reset && (r_state != ST_TWO);
        w_out_valid      = (r_state != ST_EMPTY);
        w_accept         = in_valid && w_in_ready;
        w_drain          = w_out_valid && out_ready;

        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_head_ld   = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_drain) begin
                    w_state_nxt = ST_TWO;
                    w_tail_ld   = 1'b1;
                end else if (w_drain && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept && w_drain) begin
                    w_head_ld = 1'b1;
                end
            end
            ST_TWO: begin
                if (w_drain) begin
                    w_state_nxt      = ST_ONE;
                    w_head_ld        = 1'b1;
                    w_head_from_tail = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_head_ld) begin
                r_head <= w_head_from_tail ? r_tail : w_new;
            end
            if (w_tail_ld) begin
                r_tail <= w_new;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_head.data;
`ifdef LOAD_EXT_MISALIGN_EN
    assign out_misalign = r_head.misalign;
`endif

endmodule
